// File: rtl/poly_pipe_arb_pkg.sv
// Shared definitions for the poly_pipe_arb scheduler and its evaluator.
// Keeping the evaluator latency default here keeps both blocks in step.
package poly_arb_pkg;

  localparam int DATA_W      = 32;
  localparam int LAT_DEFAULT = 4;
  localparam int MAX_REQ     = 8;
  localparam int ID_W        = $clog2(MAX_REQ);

  // A tag is a valid bit plus the ID of the requester that owns the operand.
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/poly_pipe_arb_if.sv
// Requester-side bus of poly_pipe_arb: operand handshake and result return.
// The master modport belongs to the requesters; the slave modport belongs to the scheduler.
interface poly_pipe_arb_if
  import poly_arb_pkg::*;
#(
  parameter int N_REQ = 2
);

  logic [N_REQ-1:0]        req_valid;
  logic [DATA_W*N_REQ-1:0] req_x;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]       resp_y;

  modport master (
    output req_valid,
    output req_x,
    input  req_ready,
    input  resp_valid,
    input  resp_y
  );

  modport slave (
    input  req_valid,
    input  req_x,
    output req_ready,
    output resp_valid,
    output resp_y
  );

endinterface

// File: rtl/poly_pipe_arb_rr.sv
// Combinational N_REQ-way picker used by poly_pipe_arb.
// With POLY_ARB_RR_EN defined the scan starts at ptr_i and wraps (rotate priority);
// otherwise the lowest eligible index wins and no pointer input exists.
module poly_arb_rr #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] elig_i,
`ifdef POLY_ARB_RR_EN
  input  logic [IDX_W-1:0] ptr_i,
`endif
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o
);

  logic found;

`ifdef POLY_ARB_RR_EN
  int               jInt;
  logic [IDX_W-1:0] jIdx;

  // Walk the requesters starting at the pointer and grant the first eligible one.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    jInt    = 0;
    jIdx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      jInt = (int'(ptr_i) + k) % N_REQ;
      jIdx = IDX_W'(jInt);
      if (!found && elig_i[jIdx]) begin
        found         = 1'b1;
        grant_o[jIdx] = 1'b1;
        idx_o         = jIdx;
      end
    end
  end
`else
  // Grant the lowest-numbered eligible requester.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && elig_i[k]) begin
        found      = 1'b1;
        grant_o[k] = 1'b1;
        idx_o      = IDX_W'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/poly_pipe_arb.sv
// poly_pipe_arb: shares one pipelined y = x^4 + x^2 evaluator between N_REQ requesters.
// A tag shift register of LAT+1 stages follows each operand through the evaluator so the
// result can be steered back to its owner; per-requester counters cap in-flight work.
// Build option: define POLY_ARB_RR_EN for round-robin arbitration, otherwise fixed priority.
module poly_pipe_arb
  import poly_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int LAT     = LAT_DEFAULT,
  parameter int MAX_OUT = 3
) (
  input  logic              clk,
  input  logic              rst,
  poly_pipe_arb_if.slave    reqIf,
  output logic              ev_start,
  output logic [DATA_W-1:0] ev_x,
  input  logic [DATA_W-1:0] ev_y
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  grantIdx;
  logic              accept;
  logic [N_REQ-1:0]  incVec;
  logic [N_REQ-1:0]  decVec;

  logic [CNT_W-1:0]  cnt_q [N_REQ];
  logic [CNT_W-1:0]  cnt_d [N_REQ];
  tag_t              tag_q [LAT+1];
  logic              evStart_q;
  logic [DATA_W-1:0] evX_q;
  logic [N_REQ-1:0]  respValid_q;
  logic [N_REQ-1:0]  respValid_d;
  logic [DATA_W-1:0] respY_q;

  // A requester may be granted only when it is asking, has credit left, and we are not in reset.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = reqIf.req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUT)) && !rst;
    end
  end

`ifdef POLY_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  poly_arb_rr #(.N_REQ(N_REQ), .IDX_W(IDX_W)) uPick (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grantIdx)
  );

  // After a grant the next scan starts just past the winner.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (grantIdx == IDX_W'(N_REQ - 1)) ? '0 : grantIdx + IDX_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  poly_arb_rr #(.N_REQ(N_REQ), .IDX_W(IDX_W)) uPick (
    .elig_i  (elig),
    .grant_o (grant),
    .idx_o   (grantIdx)
  );
`endif

  assign accept          = |grant;
  assign reqIf.req_ready = grant;

  // Work out credit changes and which requester the emerging result belongs to.
  always_comb begin
    incVec      = '0;
    decVec      = '0;
    respValid_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i]       = cnt_q[i];
      incVec[i]      = accept && (grantIdx == IDX_W'(i));
      decVec[i]      = tag_q[LAT].valid && (tag_q[LAT].id == ID_W'(i));
      respValid_d[i] = decVec[i];
      if (incVec[i] && !decVec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (decVec[i] && !incVec[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // Launch operands, shift tags in lockstep with the evaluator, and return results.
  always_ff @(posedge clk) begin
    if (rst) begin
      evStart_q   <= 1'b0;
      evX_q       <= '0;
      respValid_q <= '0;
      respY_q     <= '0;
      for (int s = 0; s <= LAT; s++) begin
        tag_q[s] <= '0;
      end
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      evStart_q <= accept;
      if (accept) begin
        evX_q <= reqIf.req_x[grantIdx*DATA_W +: DATA_W];
      end
      tag_q[0] <= {accept, ID_W'(grantIdx)};
      for (int s = 1; s <= LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
      respValid_q <= respValid_d;
      if (tag_q[LAT].valid) begin
        respY_q <= ev_y;
      end
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign ev_start         = evStart_q;
  assign ev_x             = evX_q;
  assign reqIf.resp_valid = respValid_q;
  assign reqIf.resp_y     = respY_q;

endmodule

// File: tb/tb_poly_pipe_arb.sv
// Directed bench for poly_pipe_arb with a behavioural LAT-stage y = x^4 + x^2 evaluator.
// Works with or without POLY_ARB_RR_EN; the contention expectations follow the build.
module tb_poly_pipe_arb;
  import poly_arb_pkg::*;

  localparam int N_REQ   = 2;
  localparam int LAT     = LAT_DEFAULT;
  localparam int MAX_OUT = 3;
  localparam int RSP_LAT = LAT + 2;

  typedef struct { int cyc; int id; logic [DATA_W-1:0] x; } acc_t;
  typedef struct { int cyc; logic [N_REQ-1:0] vld; logic [DATA_W-1:0] y; } rsp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              evStart;
  logic [DATA_W-1:0] evX;
  logic [DATA_W-1:0] evY;
  logic [DATA_W-1:0] evPipe [LAT];
  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;
  acc_t              accQ[$];
  rsp_t              rspQ[$];
  logic [12:0]       rdyPat;
  logic [9:0]        grantPat;
  logic [9:0]        anyPat;

  poly_pipe_arb_if #(.N_REQ(N_REQ)) reqIf ();

  poly_pipe_arb #(.N_REQ(N_REQ), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .reqIf    (reqIf),
    .ev_start (evStart),
    .ev_x     (evX),
    .ev_y     (evY)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] polyRef(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] sq;
    sq = x * x;
    return sq * sq + sq;
  endfunction

  // Evaluator stand-in: samples ev_x every edge, result appears LAT edges later.
  always @(posedge clk) begin
    evPipe[0] <= polyRef(evX);
    for (int i = 1; i < LAT; i++) evPipe[i] <= evPipe[i-1];
  end
  assign evY = evPipe[LAT-1];

  // Record every handshake and every result pulse mid-cycle.
  always @(negedge clk) begin
    acc_t a;
    rsp_t r;
    for (int i = 0; i < N_REQ; i++) begin
      if (reqIf.req_valid[i] && reqIf.req_ready[i]) begin
        a.cyc = cyc;
        a.id  = i;
        a.x   = reqIf.req_x[i*DATA_W +: DATA_W];
        accQ.push_back(a);
      end
    end
    if (reqIf.resp_valid != '0) begin
      r.cyc = cyc;
      r.vld = reqIf.resp_valid;
      r.y   = reqIf.resp_y;
      rspQ.push_back(r);
    end
  end

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] v, input logic [DATA_W-1:0] x0,
                               input logic [DATA_W-1:0] x1);
    reqIf.req_valid = v;
    reqIf.req_x     = {x1, x0};
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Pair each accepted operand with the response that should come back for it.
  task automatic checkDrained(input string tag, input int expCount);
    checkOutput({tag, "_nacc"}, 32'(accQ.size()), 32'(expCount));
    checkOutput({tag, "_nrsp"}, 32'(rspQ.size()), 32'(expCount));
    for (int i = 0; i < accQ.size() && i < rspQ.size(); i++) begin
      checkOutput({tag, "_lat"}, 32'(rspQ[i].cyc - accQ[i].cyc), 32'(RSP_LAT));
      checkOutput({tag, "_vld"}, 32'(rspQ[i].vld), 32'(1) << accQ[i].id);
      checkOutput({tag, "_y"}, rspQ[i].y, polyRef(accQ[i].x));
    end
  endtask

  task automatic sendOne(input string tag, input int id, input logic [DATA_W-1:0] x,
                         input logic [DATA_W-1:0] expY);
    accQ.delete();
    rspQ.delete();
    nextCycle();
    applyStimulus(N_REQ'(1) << id, x, x);
    @(negedge clk);
    checkOutput({tag, "_rdy"}, 32'(reqIf.req_ready), 32'(1) << id);
    nextCycle();
    applyStimulus('0, '0, '0);
    repeat (RSP_LAT + 3) nextCycle();
    checkDrained(tag, 1);
    if (rspQ.size() > 0) checkOutput({tag, "_yexp"}, rspQ[0].y, expY);
  endtask

  initial begin
    // Reset with requests pending: nothing may be granted or emitted.
    applyStimulus(2'b11, 32'h1234, 32'h5678);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 32'(reqIf.req_ready), 32'h0);
    checkOutput("rst_start", 32'(evStart), 32'h0);
    checkOutput("rst_evx", evX, 32'h0);
    checkOutput("rst_rvalid", 32'(reqIf.resp_valid), 32'h0);
    checkOutput("rst_respy", reqIf.resp_y, 32'h0);
    nextCycle();
    rst = 1'b0;
    applyStimulus('0, '0, '0);

    // Single operations, including 32-bit wrap-around.
    sendOne("op_x3", 0, 32'd3, 32'd90);
    sendOne("op_x2", 0, 32'd2, 32'd20);
    sendOne("op_x0", 0, 32'd0, 32'd0);
    sendOne("op_ffff", 1, 32'h0000FFFF, 32'hFFFA0002);
    sendOne("op_10000", 1, 32'h00010000, 32'h00000000);

    // Outstanding limit on requester 1 alone: 3 accepts, 3 stalls, repeat.
    accQ.delete();
    rspQ.delete();
    nextCycle();
    applyStimulus(2'b10, 32'd0, 32'd2);
    rdyPat = '0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      rdyPat[k] = reqIf.req_ready[1];
      if (k < 12) nextCycle();
    end
    nextCycle();
    applyStimulus('0, '0, '0);
    checkOutput("limit_rdy", 32'(rdyPat), 32'(13'b1000111000111));
    repeat (RSP_LAT + 4) nextCycle();
    checkDrained("limit", 7);

    // Contention: both requesters valid every cycle.
    accQ.delete();
    rspQ.delete();
    nextCycle();
    applyStimulus(2'b11, 32'd1, 32'd2);
    grantPat = '0;
    anyPat   = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      grantPat[k] = reqIf.req_ready[1];
      anyPat[k]   = |reqIf.req_ready;
      if (k < 9) nextCycle();
    end
    nextCycle();
    applyStimulus('0, '0, '0);
`ifdef POLY_ARB_RR_EN
    checkOutput("rr_grant", 32'(grantPat), 32'(10'b1010101010));
`else
    checkOutput("fp_grant", 32'(grantPat), 32'(10'b1000111000));
`endif
    checkOutput("cont_any", 32'(anyPat), 32'h3FF);
    repeat (RSP_LAT + 3) nextCycle();
    checkDrained("cont", 10);
    if (rspQ.size() == 10) checkOutput("cont_span", 32'(rspQ[9].cyc - rspQ[0].cyc), 32'd9);

    // Reset while x=5 is in flight: its result must never surface.
    accQ.delete();
    rspQ.delete();
    nextCycle();
    applyStimulus(2'b01, 32'd5, 32'd0);
    nextCycle();
    applyStimulus('0, '0, '0);
    nextCycle();
    nextCycle();
    rst = 1'b1;
    applyStimulus(2'b11, 32'd1, 32'd2);
    @(negedge clk);
    checkOutput("midrst_rdy", 32'(reqIf.req_ready), 32'h0);
    nextCycle();
    rst = 1'b0;
    applyStimulus('0, '0, '0);
    repeat (RSP_LAT + 3) nextCycle();
    checkOutput("midrst_nrsp", 32'(rspQ.size()), 32'h0);
    checkOutput("midrst_start", 32'(evStart), 32'h0);

    // Requester 0 must have its full credit back after the reset.
    accQ.delete();
    rspQ.delete();
    nextCycle();
    applyStimulus(2'b01, 32'd7, 32'd0);
    rdyPat = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rdyPat[k] = reqIf.req_ready[0];
      if (k < 4) nextCycle();
    end
    nextCycle();
    applyStimulus('0, '0, '0);
    checkOutput("midrst_credit", 32'(rdyPat), 32'(5'b00111));
    repeat (RSP_LAT + 3) nextCycle();
    checkDrained("midrst_credit", 3);
    sendOne("post_rst", 0, 32'd3, 32'd90);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
